// File: rtl/multi_breathe_led_pkg.sv
// Shared definitions for the multi-channel breathing LED driver:
// per-channel mode encoding and the prescaler divide calculation.
package multi_breathe_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  // Clocks per ramp step: one breath period spans 2**(pwm_bits+1) steps.
  function automatic int unsigned calc_step_div(input longint unsigned clk_freq,
                                                input longint unsigned breath_ms,
                                                input int unsigned     pwm_bits);
    longint unsigned clk_per_period;
    clk_per_period = (clk_freq / 64'd1000) * breath_ms;
    return int'(clk_per_period >> (pwm_bits + 1));
  endfunction

endpackage

// File: rtl/multi_breathe_led_if.sv
// Control/status bundle between board logic and the LED driver.
// Level-sampled signals only: no valid/ready handshake; mode changes take effect at the next PWM frame.
interface multi_breathe_led_if #(
  parameter int CH = 4
);
  logic            en;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   led;
  logic            period_pulse;

  modport master (output en, mode, input led, period_pulse);
  modport slave  (input en, mode, output led, period_pulse);
endinterface

// File: rtl/breathe_led_channel.sv
// One LED channel: phase stagger, triangle level, frame-edge latch,
// lit decision and registered pin output.
module breathe_led_channel
  import multi_breathe_led_pkg::*;
#(
  parameter int          PWM_BITS   = 9,
  parameter int          ACTIVE_LOW = 1,
  parameter int unsigned OFFSET     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                frame_start,
  input  logic [PWM_BITS:0]   phase,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [1:0]          mode_in,
  output logic                led
);

  localparam int          PH_W  = PWM_BITS + 1;
  localparam logic [PWM_BITS:0] OFF = PH_W'(OFFSET);
  localparam logic        INACT = (ACTIVE_LOW != 0);

  logic [PWM_BITS:0]   ph;
  logic [PWM_BITS-1:0] lvl;
  mode_e               mode_lat;
  logic [PWM_BITS-1:0] lvl_lat;
  logic                blink_lat;
  mode_e               cur_mode;
  logic [PWM_BITS-1:0] cur_lvl;
  logic                cur_blink;
  logic                lit;

  assign ph  = phase + OFF;
  assign lvl = ph[PWM_BITS] ? ph[PWM_BITS-1:0] : ~ph[PWM_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_lat  <= MODE_OFF;
      lvl_lat   <= '0;
      blink_lat <= 1'b0;
    end else if (frame_start) begin
      mode_lat  <= mode_e'(mode_in);
      lvl_lat   <= lvl;
      blink_lat <= ~ph[PWM_BITS];
    end
  end

  // On the frame's first count the freshly sampled values are used directly,
  // so every frame is rendered entirely from one consistent setting.
  always_comb begin
    cur_mode  = frame_start ? mode_e'(mode_in) : mode_lat;
    cur_lvl   = frame_start ? lvl : lvl_lat;
    cur_blink = frame_start ? ~ph[PWM_BITS] : blink_lat;
    lit       = 1'b0;
    case (cur_mode)
      MODE_OFF:     lit = 1'b0;
      MODE_ON:      lit = 1'b1;
      MODE_BREATHE: lit = (pwm_cnt < cur_lvl);
      MODE_BLINK:   lit = cur_blink;
      default:      lit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= INACT;
    else        led <= en ? (lit ^ INACT) : INACT;
  end

endmodule

// File: rtl/multi_breathe_led.sv
// Multi-channel breathing LED driver: shared prescaler, triangle phase ramp
// and PWM frame counter feeding CH staggered channel instances.
module multi_breathe_led
  import multi_breathe_led_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BREATH_MS  = 2000,
  parameter int CH         = 4,
  parameter int PWM_BITS   = 9,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_breathe_led_if.slave bus
);

  localparam int unsigned STEP_DIV = calc_step_div(CLK_FREQ, BREATH_MS, PWM_BITS);
  localparam int          PH_W     = PWM_BITS + 1;
  localparam int unsigned PH_SPAN  = 2 ** PH_W;

  if (STEP_DIV < 1) begin : g_bad_step
    $error("multi_breathe_led: breath period too short for PWM_BITS");
  end
  if (CH < 1 || CH > 16) begin : g_bad_ch
    $error("multi_breathe_led: CH must be 1..16");
  end

  logic [31:0]         presc;
  logic [PWM_BITS:0]   phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pp_q;
  logic                step_tick;
  logic                frame_start;
  logic [CH-1:0]       led_w;

  assign step_tick   = bus.en && (presc == 32'(STEP_DIV - 1));
  assign frame_start = bus.en && (pwm_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      phase   <= '0;
      pwm_cnt <= '0;
      pp_q    <= 1'b0;
    end else begin
      pp_q <= step_tick && (phase == '1);
      if (bus.en) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        if (step_tick) begin
          presc <= '0;
          phase <= phase + PH_W'(1);
        end else begin
          presc <= presc + 32'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    breathe_led_channel #(
      .PWM_BITS  (PWM_BITS),
      .ACTIVE_LOW(ACTIVE_LOW),
      .OFFSET    (i * (PH_SPAN / CH))
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (bus.en),
      .frame_start(frame_start),
      .phase      (phase),
      .pwm_cnt    (pwm_cnt),
      .mode_in    (bus.mode[2*i +: 2]),
      .led        (led_w[i])
    );
  end

  assign bus.led          = led_w;
  assign bus.period_pulse = pp_q;

endmodule
